axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing one AXI-Stream (axis) master among N_PORTS axis slaves.
//  Sits between multiple stream producers (DMA channels, user kernels) and a single shell stream sink.
//  Grants are held until the granted packet's tlast beat completes, so packets are never interleaved.
// PARAMETERS
//  N_PORTS     4   number of requesting slave streams (2..16)
//  DATA_WIDTH  32  tdata width; tkeep/tstrb width = DATA_WIDTH/8
//  ID_WIDTH    1   tid width
//  DEST_WIDTH  1   tdest width
//  USER_WIDTH  1   tuser width
//  IDXW = max(1,$clog2(N_PORTS)) (localparam, grant index width)
// PORTS
//  clk            in   1                    clock; all logic on rising edge
//  rst            in   1                    synchronous reset, active-high
//  s_axis_tvalid  in   N_PORTS              per-port tvalid
//  s_axis_tready  out  N_PORTS              per-port tready
//  s_axis_tdata   in   N_PORTS*DATA_WIDTH   port p at [p*DATA_WIDTH +: DATA_WIDTH]; same packing below
//  s_axis_tstrb   in   N_PORTS*DATA_WIDTH/8 per-port tstrb
//  s_axis_tkeep   in   N_PORTS*DATA_WIDTH/8 per-port tkeep
//  s_axis_tlast   in   N_PORTS              per-port tlast
//  s_axis_tid     in   N_PORTS*ID_WIDTH     per-port tid
//  s_axis_tdest   in   N_PORTS*DEST_WIDTH   per-port tdest
//  s_axis_tuser   in   N_PORTS*USER_WIDTH   per-port tuser
//  m_axis_t*      out/in                    one axis master: tvalid,tdata,tstrb,tkeep,tlast,tid,tdest,tuser out; tready in
//  grant_idx      out  IDXW                 index of currently/last granted port
//  busy           out  1                    1 while a packet is in flight (state BUSY)
//  pkt_cnt        out  32                   completed packets since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset: state=IDLE, grant_idx=0, last=N_PORTS-1, busy=0,
//    pkt_cnt=0, m_axis_tvalid=0, all s_axis_tready=0. Reset mid-packet drops the packet; no flush.
//  - FSM IDLE: all s_axis_tready=0, m_axis_tvalid=0. If any s_axis_tvalid, select first port with tvalid
//    searching last+1, last+2, ... (mod N_PORTS); register grant_idx=that, last=that; -> BUSY.
//  - FSM BUSY: m_axis_* = s_axis_*[grant_idx] (combinational mux); s_axis_tready[grant_idx]=m_axis_tready,
//    other treadys 0. Beat transfers when m_axis_tvalid&&m_axis_tready. On transfer with tlast=1:
//    -> IDLE, pkt_cnt+=1. Zero-latency data path; one-cycle arbitration bubble between packets.
//  - Granted port deasserting tvalid mid-packet: grant held, m_axis_tvalid follows it (no re-arbitration).
//  - Single requester: served every packet, with the bubble cycle between packets.
//  - Simultaneous requests in IDLE: rotating priority guarantees each waiting port is granted within
//    N_PORTS packets. Requests arriving during BUSY wait until IDLE.
//  - tvalid on ungranted ports never sees tready; their data must stay stable (AXI-Stream rule).
// CONFIGURATION
//  AXIS_ARB_SRCID_EN defined: m_axis_tid = zero-extended grant_idx (source port tag); requires
//    ID_WIDTH >= IDXW; elaboration $error otherwise. Slave tid inputs ignored.
//  AXIS_ARB_SRCID_EN undefined: m_axis_tid = s_axis_tid[grant_idx] passthrough.
// TESTING
//  1 rst=1 2 cycles, all tvalid=1 -> all tready=0, m_tvalid=0, pkt_cnt=0, grant_idx=0, busy=0.
//  2 Ports 0..3 each hold 3-beat pkt (tdata=p*16+beat), m_tready=1 -> output order p0,p1,p2,p3,
//    12 beats, 1 bubble per packet, pkt_cnt=4, no interleave.
//  3 After grant to p2, only p1,p3 requesting -> next grant p3, then p1.
//  4 m_tready toggles 1/0 every cycle on 4-beat pkt -> beats intact, s_tready[g] mirrors m_tready, busy=1 until tlast.
//  5 rst asserted on beat 2 of 4 -> next cycle IDLE, pkt_cnt unchanged, next grant from port 0.
//  6 AXIS_ARB_SRCID_EN, ID_WIDTH=2, pkt from p3 with s_tid=0 -> m_axis_tid=3 every beat.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-Stream
// master among N_PORTS slave streams. A grant is held until the granted
// packet's tlast beat transfers, so packets are never interleaved. The data
// path is a zero-latency mux, and there is one arbitration bubble between
// packets.
// Optional build macro AXIS_ARB_SRCID_EN: m_axis_tid carries the granted port
// index (zero-extended) instead of passing the slave tid through.
module axis_rr_arbiter #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1,
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned IDXW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORTS-1:0]               s_axis_tvalid,
    output logic [N_PORTS-1:0]               s_axis_tready,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [N_PORTS*KEEP_WIDTH-1:0]    s_axis_tstrb,
    input  logic [N_PORTS*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [N_PORTS-1:0]               s_axis_tlast,
    input  logic [N_PORTS*ID_WIDTH-1:0]      s_axis_tid,
    input  logic [N_PORTS*DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [N_PORTS*USER_WIDTH-1:0]    s_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tstrb,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [IDXW-1:0]                  grant_idx,
    output logic                             busy,
    output logic [31:0]                      pkt_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;

    logic              req_any_c;
    logic [IDXW-1:0]   sel_idx_c;
    logic [IDXW-1:0]   cand_c;
    logic              pkt_done_c;

`ifdef AXIS_ARB_SRCID_EN
    // The source tag must fit in the master tid field.
    if (ID_WIDTH < IDXW) begin : g_srcid_width_chk
        $error("axis_rr_arbiter: AXIS_ARB_SRCID_EN needs ID_WIDTH >= IDXW");
    end

    logic unused_tid_c;
    assign unused_tid_c = ^s_axis_tid;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Rotating-priority pick: first requester after the last granted port.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        req_any_c = |s_axis_tvalid;
        sel_idx_c = last_q;
        cand_c    = '0;
        for (int unsigned i = N_PORTS; i > 0; i--) begin
            cand_c = IDXW'((32'(last_q) + i) % N_PORTS);
            if (s_axis_tvalid[cand_c]) begin
                sel_idx_c = cand_c;
            end
        end
    end

    // The final beat of the granted packet is handshaking this cycle.
    assign pkt_done_c = (state_q == S_BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any_c)  state_d = S_BUSY;
            S_BUSY:  if (pkt_done_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output mux: only the granted port is connected while a packet is in flight.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tid    = '0;
        m_axis_tdest  = '0;
        m_axis_tuser  = '0;
        if (state_q == S_BUSY) begin
            m_axis_tvalid = s_axis_tvalid[grant_q];
            m_axis_tdata  = s_axis_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            m_axis_tstrb  = s_axis_tstrb[32'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tkeep  = s_axis_tkeep[32'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tlast  = s_axis_tlast[grant_q];
`ifdef AXIS_ARB_SRCID_EN
            m_axis_tid    = ID_WIDTH'(grant_q);
`else
            m_axis_tid    = s_axis_tid[32'(grant_q) * ID_WIDTH +: ID_WIDTH];
`endif
            m_axis_tdest  = s_axis_tdest[32'(grant_q) * DEST_WIDTH +: DEST_WIDTH];
            m_axis_tuser  = s_axis_tuser[32'(grant_q) * USER_WIDTH +: USER_WIDTH];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    // Grant, rotation pointer and packet counter next values.
    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        if ((state_q == S_IDLE) && req_any_c) begin
            grant_d = sel_idx_c;
            last_d  = sel_idx_c;
        end
        if (pkt_done_c) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    // Grant, rotation pointer and packet counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            last_q    <= IDXW'(N_PORTS - 1);
            pkt_cnt_q <= '0;
        end else begin
            grant_q   <= grant_d;
            last_q    <= last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == S_BUSY);
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Testbench for axis_rr_arbiter: directed vector tables, hand-written corner
// sequences and randomized packet traffic against a packet-level model.
module tb_axis_rr_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned IW   = 2;
    localparam int unsigned DSW  = 1;
    localparam int unsigned UW   = 1;
    localparam int unsigned IDXW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tstrb;
    logic [N*KW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N*IW-1:0]   s_tid;
    logic [N*DSW-1:0]  s_tdest;
    logic [N*UW-1:0]   s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tstrb;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic [DSW-1:0]    m_tdest;
    logic [UW-1:0]     m_tuser;
    logic [IDXW-1:0]   grant_idx;
    logic              busy;
    logic [31:0]       pkt_cnt;

    axis_rr_arbiter #(
        .N_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tstrb(s_tstrb), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [KW-1:0]  strb;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
        logic           first;
    } beat_t;

    typedef struct {
        beat_t b;
        int    port;
    } exp_t;

    typedef struct {
        beat_t           b;
        logic [IDXW-1:0] grant;
    } mon_t;

    typedef struct {
        logic        mready;
        logic        mvalid;
        logic [31:0] data;
        logic        mlast;
        logic        busy;
        logic [1:0]  grant;
        logic [3:0]  sready;
        logic [31:0] cnt;
        bit          load_after;
    } vec_t;

    beat_t src_q [N][$];
    beat_t mdl_q [N][$];
    exp_t  exp_q [$];
    mon_t  mon_q [$];
    vec_t  vecs  [$];
    int    gap   [N];
    bit    gap_en = 1'b0;
    logic [N-1:0] fire_v;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present each port's queue head; gaps hold tvalid low mid-packet.
    task automatic drive_all();
        beat_t b;
        for (int p = 0; p < N; p++) begin
            if (src_q[p].size() > 0 && gap[p] == 0) begin
                b = src_q[p][0];
                s_tvalid[p]                = 1'b1;
                s_tdata[p*DW +: DW]        = b.data;
                s_tstrb[p*KW +: KW]        = b.strb;
                s_tkeep[p*KW +: KW]        = b.keep;
                s_tlast[p]                 = b.last;
                s_tid[p*IW +: IW]          = b.id;
                s_tdest[p*DSW +: DSW]      = b.dest;
                s_tuser[p*UW +: UW]        = b.user;
            end else begin
                s_tvalid[p] = 1'b0;
                if (gap[p] > 0) gap[p]--;
            end
        end
    endtask

    // Source drivers: handshake sampled mid-cycle, queues advanced after the edge.
    initial begin
        s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
        s_tlast = '0; s_tid = '0; s_tdest = '0; s_tuser = '0;
        for (int p = 0; p < N; p++) gap[p] = 0;
        drive_all();
        forever begin
            @(negedge clk);
            fire_v = rst ? '0 : (s_tvalid & s_tready);
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (fire_v[p] && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    if (gap_en && src_q[p].size() > 0 && !src_q[p][0].first &&
                        $urandom_range(0, 2) == 0)
                        gap[p] = int'($urandom_range(1, 2));
                end
            end
            drive_all();
        end
    end

    // Master-side monitor.
    initial begin
        mon_t m;
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
                m.b.data = m_tdata; m.b.strb = m_tstrb; m.b.keep = m_tkeep;
                m.b.last = m_tlast; m.b.id = m_tid; m.b.dest = m_tdest;
                m.b.user = m_tuser; m.b.first = 1'b0; m.grant = grant_idx;
                mon_q.push_back(m);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input int p, input int len, input logic [31:0] base, input bit to_model);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + 32'(i); b.strb = '1; b.keep = '1;
            b.last = (i == len - 1); b.id = '0; b.dest = DSW'(p % 2);
            b.user = UW'(i % 2); b.first = (i == 0);
            src_q[p].push_back(b);
            if (to_model) mdl_q[p].push_back(b);
        end
    endtask

    task automatic rand_pkt(input int p);
        beat_t b;
        int len;
        len = int'($urandom_range(1, 5));
        for (int i = 0; i < len; i++) begin
            b.data = $urandom(); b.strb = KW'($urandom()); b.keep = KW'($urandom());
            b.last = (i == len - 1); b.id = IW'($urandom()); b.dest = DSW'($urandom());
            b.user = UW'($urandom()); b.first = (i == 0);
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Reset asserted immediately, held for n edges; sources are emptied.
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            gap[p] = 0;
        end
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic wait_mon(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (mon_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 64'(mon_q.size() >= n), 64'd1);
    endtask

    function automatic void av(input logic mr, input logic mv, input logic [31:0] d, input logic ml,
                               input logic bz, input logic [1:0] g, input logic [3:0] sr,
                               input logic [31:0] cnt, input bit ld);
        vec_t v;
        v.mready = mr; v.mvalid = mv; v.data = d; v.mlast = ml; v.busy = bz;
        v.grant = g; v.sready = sr; v.cnt = cnt; v.load_after = ld;
        vecs.push_back(v);
    endfunction

    // Packet-level round robin: all packets queued up front, so each pick is the
    // next port after the previous winner that still has a packet.
    task automatic build_expected(output int npkts);
        int last_p, p;
        bit any;
        exp_t e;
        npkts  = 0;
        last_p = N - 1;
        exp_q.delete();
        forever begin
            any = 1'b0;
            p = 0;
            for (int i = 1; i <= N && !any; i++) begin
                if (mdl_q[(last_p + i) % N].size() > 0) begin
                    p = (last_p + i) % N;
                    any = 1'b1;
                end
            end
            if (!any) break;
            do begin
                e.b = mdl_q[p].pop_front();
                e.port = p;
                exp_q.push_back(e);
            end while (!e.b.last);
            last_p = p;
            npkts++;
        end
    endtask

    task automatic cmp_beat(input int k, input mon_t m, input exp_t e);
        logic [IW-1:0] eid;
        bit ok;
`ifdef AXIS_ARB_SRCID_EN
        eid = IW'(e.port);
`else
        eid = e.b.id;
`endif
        ok = (m.b.data === e.b.data) && (m.b.strb === e.b.strb) && (m.b.keep === e.b.keep) &&
             (m.b.last === e.b.last) && (m.b.id === eid) && (m.b.dest === e.b.dest) &&
             (m.b.user === e.b.user) && (m.grant === IDXW'(e.port));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rand_beat[%0d]: got data=%h strb=%h keep=%h last=%b id=%h dest=%h user=%h grant=%0d expected data=%h strb=%h keep=%h last=%b id=%h dest=%h user=%h port=%0d",
                     k, m.b.data, m.b.strb, m.b.keep, m.b.last, m.b.id, m.b.dest, m.b.user, m.grant,
                     e.b.data, e.b.strb, e.b.keep, e.b.last, eid, e.b.dest, e.b.user, e.port);
        end
    endtask

    initial begin
        int npkts, found, c;
        rst = 1'b1;
        m_tready = 1'b0;

        // Packets 0..3 (3 beats each) followed by a 4-beat packet on port 1 under toggling tready.
        av(1, 0, 0,  0, 0, 0, 4'b0000, 0, 0);
        av(1, 1, 0,  0, 1, 0, 4'b0001, 0, 0);
        av(1, 1, 1,  0, 1, 0, 4'b0001, 0, 0);
        av(1, 1, 2,  1, 1, 0, 4'b0001, 0, 0);
        av(1, 0, 0,  0, 0, 0, 4'b0000, 1, 0);
        av(1, 1, 16, 0, 1, 1, 4'b0010, 1, 0);
        av(1, 1, 17, 0, 1, 1, 4'b0010, 1, 0);
        av(1, 1, 18, 1, 1, 1, 4'b0010, 1, 0);
        av(1, 0, 0,  0, 0, 1, 4'b0000, 2, 0);
        av(1, 1, 32, 0, 1, 2, 4'b0100, 2, 0);
        av(1, 1, 33, 0, 1, 2, 4'b0100, 2, 0);
        av(1, 1, 34, 1, 1, 2, 4'b0100, 2, 0);
        av(1, 0, 0,  0, 0, 2, 4'b0000, 3, 0);
        av(1, 1, 48, 0, 1, 3, 4'b1000, 3, 0);
        av(1, 1, 49, 0, 1, 3, 4'b1000, 3, 0);
        av(1, 1, 50, 1, 1, 3, 4'b1000, 3, 0);
        av(1, 0, 0,  0, 0, 3, 4'b0000, 4, 1);
        av(1, 0, 0,     0, 0, 3, 4'b0000, 4, 0);
        av(1, 1, 'hA0,  0, 1, 1, 4'b0010, 4, 0);
        av(0, 1, 'hA1,  0, 1, 1, 4'b0000, 4, 0);
        av(1, 1, 'hA1,  0, 1, 1, 4'b0010, 4, 0);
        av(0, 1, 'hA2,  0, 1, 1, 4'b0000, 4, 0);
        av(1, 1, 'hA2,  0, 1, 1, 4'b0010, 4, 0);
        av(0, 1, 'hA3,  1, 1, 1, 4'b0000, 4, 0);
        av(1, 1, 'hA3,  1, 1, 1, 4'b0010, 4, 0);
        av(0, 0, 0,     0, 0, 1, 4'b0000, 5, 0);

        // Reset with every port requesting.
        for (int p = 0; p < N; p++) load_pkt(p, 3, 32'(p * 16), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid_all", 64'(s_tvalid), 64'hF);
        chk("rst_s_tready", 64'(s_tready), 64'h0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
        chk("rst_grant", 64'(grant_idx), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            m_tready = vecs[i].mready;
            @(negedge clk);
            chk($sformatf("vec%0d_mvalid", i), 64'(m_tvalid), 64'(vecs[i].mvalid));
            if (vecs[i].mvalid) begin
                chk($sformatf("vec%0d_data", i), 64'(m_tdata), 64'(vecs[i].data));
                chk($sformatf("vec%0d_last", i), 64'(m_tlast), 64'(vecs[i].mlast));
            end
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
            chk($sformatf("vec%0d_grant", i), 64'(grant_idx), 64'(vecs[i].grant));
            chk($sformatf("vec%0d_sready", i), 64'(s_tready), 64'(vecs[i].sready));
            chk($sformatf("vec%0d_cnt", i), 64'(pkt_cnt), 64'(vecs[i].cnt));
            if (vecs[i].load_after) load_pkt(1, 4, 32'hA0, 0);
        end

        // After a grant to port 2, ports 1 and 3 request: port 3 then port 1.
        do_reset(2);
        m_tready = 1'b1;
        load_pkt(2, 2, 32'd32, 0);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clk);
            if (busy && grant_idx == 2'd2) found = 1;
        end
        chk("t3_grant_p2", 64'(found), 64'd1);
        load_pkt(1, 2, 32'd16, 0);
        load_pkt(3, 2, 32'd48, 0);
        wait_mon("t3_timeout", 6, 100);
        if (mon_q.size() >= 6) begin
            chk("t3_pkt0_data", 64'(mon_q[0].b.data), 64'd32);
            chk("t3_pkt1_data", 64'(mon_q[2].b.data), 64'd48);
            chk("t3_pkt1_grant", 64'(mon_q[2].grant), 64'd3);
            chk("t3_pkt2_data", 64'(mon_q[4].b.data), 64'd16);
            chk("t3_pkt2_grant", 64'(mon_q[4].grant), 64'd1);
`ifdef AXIS_ARB_SRCID_EN
            chk("t6_srcid_b0", 64'(mon_q[2].b.id), 64'd3);
            chk("t6_srcid_b1", 64'(mon_q[3].b.id), 64'd3);
`else
            chk("t6_tid_b0", 64'(mon_q[2].b.id), 64'd0);
            chk("t6_tid_b1", 64'(mon_q[3].b.id), 64'd0);
`endif
        end
        repeat (2) @(negedge clk);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Reset on the second beat of a 4-beat packet.
        do_reset(2);
        m_tready = 1'b1;
        load_pkt(1, 4, 32'hC0, 0);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        chk("t5_busy_seen", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        do_reset(1);
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mvalid", 64'(m_tvalid), 64'd0);
        chk("t5_sready", 64'(s_tready), 64'd0);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
        load_pkt(3, 1, 32'd48, 0);
        load_pkt(0, 1, 32'd0, 0);
        wait_mon("t5_timeout", 2, 50);
        if (mon_q.size() >= 2) begin
            chk("t5_first_grant", 64'(mon_q[0].grant), 64'd0);
            chk("t5_first_data", 64'(mon_q[0].b.data), 64'd0);
            chk("t5_second_grant", 64'(mon_q[1].grant), 64'd3);
        end

        // Randomized traffic with back-pressure and mid-packet tvalid gaps.
        for (int r = 0; r < 4; r++) begin
            do_reset(2);
            gap_en = 1'b1;
            for (int p = 0; p < N; p++) begin
                int np;
                np = int'($urandom_range(0, 3));
                for (int k = 0; k < np; k++) rand_pkt(p);
            end
            build_expected(npkts);
            c = 0;
            while (mon_q.size() < exp_q.size() && c < 3000) begin
                @(posedge clk);
                #1;
                m_tready = ($urandom_range(0, 9) < 7);
                @(negedge clk);
                c++;
            end
            @(posedge clk);
            #1;
            m_tready = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("rand%0d_beats", r), 64'(mon_q.size()), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) cmp_beat(k, mon_q[k], exp_q[k]);
            chk($sformatf("rand%0d_pkt_cnt", r), 64'(pkt_cnt), 64'(npkts));
            chk($sformatf("rand%0d_idle", r), 64'(busy), 64'd0);
            gap_en = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
